// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer (CTRL/PRESET/COUNT) with one-shot and auto-reload modes.
// Writes take effect at the clock edge; rdata is combinational; irq is FLAG & IM, both registered.
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        sel,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        mode_auto;
  logic        flag_set;

  // Upper address bits are decoded by the bridge via sel.
  logic        unused_addr;
  assign unused_addr = ^addr[29:2];

  assign wr_en     = sel && (byteen != 4'b0000);
  assign wr_ctrl   = wr_en && (addr[1:0] == OFS_CTRL);
  assign wr_preset = wr_en && (addr[1:0] == OFS_PRESET);
  assign mode_auto = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // A preset of 0 lands here too, so it behaves like a preset of 1.
          count_d  = 32'd0;
          flag_set = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_auto) begin
          state_d = ST_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus write to CTRL overrides the FSM clearing EN in the same cycle.
    if (wr_ctrl && byteen[0]) ctrl_d = wdata[3:0];

    for (int i = 0; i < 4; i++) begin
      if (wr_preset && byteen[i]) preset_d[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

  always_comb begin
    flag_d = flag_q;
    if (state_q == ST_INT && mode_auto) flag_d = 1'b0;
    if (wr_ctrl || wr_preset)           flag_d = 1'b0;
    if (flag_set)                       flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 4'h0;
      preset_q <= PRESET_RST;
      count_q  <= 32'h0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (addr[1:0])
        OFS_CTRL:   rdata = {28'h0, ctrl_q};
        OFS_PRESET: rdata = preset_q;
        OFS_COUNT:  rdata = count_q;
        default:    rdata = 32'h0;
      endcase
    end
  end

  assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: inputs change on the falling edge, outputs sampled there too.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic        sel;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [29:0] A_CTRL   = 30'h1fc0;
  localparam logic [29:0] A_PRESET = 30'h1fc1;
  localparam logic [29:0] A_COUNT  = 30'h1fc2;

  timer_counter #(.PRESET_RST(32'h0)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .sel    (sel),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    sel = 1'b1; addr = a; byteen = be; wdata = d;
    @(negedge clk);
    sel = 1'b0; byteen = 4'b0000; wdata = 32'h0;
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    sel = 1'b1; addr = a; byteen = 4'b0000;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b0; sel = 1'b0; addr = 30'h0; byteen = 4'b0000; wdata = 32'h0;
    cycles(3);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    rd(A_CTRL, v);   chk("rst_ctrl", v, 32'h0);
    rd(A_PRESET, v); chk("rst_preset", v, 32'h0);
    rd(A_COUNT, v);  chk("rst_count", v, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("sel0_rdata", rdata, 32'h0);

    // One-shot, PRESET=5, CTRL=EN|IM
    wr(A_PRESET, 4'hf, 32'd5);
    wr(A_CTRL, 4'h1, 32'h9);               // now just after E0
    cycles(2);
    rd(A_COUNT, v); chk("os_count_e2", v, 32'd5);
    cycles(4);
    rd(A_COUNT, v); chk("os_count_e6", v, 32'd1);
    chk("os_irq_e6", {31'h0, irq}, 32'h0);
    cycles(1);
    chk("os_irq_e7", {31'h0, irq}, 32'h1);
    rd(A_COUNT, v); chk("os_count_e7", v, 32'd0);
    cycles(1);
    rd(A_CTRL, v); chk("os_ctrl_e8", v, 32'h8);
    cycles(4);
    chk("os_irq_held", {31'h0, irq}, 32'h1);
    wr(A_CTRL, 4'h1, 32'h0);
    chk("os_irq_cleared", {31'h0, irq}, 32'h0);

    // Auto-reload, PRESET=3: irq pulses after E5, E10, E15, E20
    wr(A_PRESET, 4'hf, 32'd3);
    wr(A_CTRL, 4'h1, 32'hb);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      chk($sformatf("ar_irq_e%0d", k), {31'h0, irq}, {31'h0, (k % 5 == 0)});
    end
    wr(A_CTRL, 4'h1, 32'h0);
    cycles(3);
    chk("ar_stopped_irq", {31'h0, irq}, 32'h0);

    // Byte-lane write
    wr(A_PRESET, 4'hf, 32'h11223344);
    wr(A_PRESET, 4'b0100, 32'h00AA0000);
    rd(A_PRESET, v); chk("byte_lane", v, 32'h11AA3344);

    // Stop mid-count, then restart
    wr(A_PRESET, 4'hf, 32'd10);
    wr(A_CTRL, 4'h1, 32'h9);
    cycles(6);
    rd(A_COUNT, v); chk("stop_count6", v, 32'd6);
    wr(A_CTRL, 4'h1, 32'h8);
    rd(A_COUNT, v); chk("stop_count5", v, 32'd5);
    cycles(5);
    rd(A_COUNT, v); chk("stop_hold", v, 32'd5);
    chk("stop_irq", {31'h0, irq}, 32'h0);
    wr(A_CTRL, 4'h1, 32'h9);
    cycles(2);
    rd(A_COUNT, v); chk("restart_count", v, 32'd10);

    // Async reset between edges at COUNT=4
    cycles(6);
    rd(A_COUNT, v); chk("pre_rst_count", v, 32'd4);
    #1 reset = 1'b0;
    rd(A_COUNT, v); chk("arst_count", v, 32'h0);
    rd(A_CTRL, v);  chk("arst_ctrl", v, 32'h0);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // PRESET=0 behaves like PRESET=1: irq after E3
    wr(A_PRESET, 4'hf, 32'd0);
    wr(A_CTRL, 4'h1, 32'h9);
    cycles(2);
    chk("p0_irq_e2", {31'h0, irq}, 32'h0);
    cycles(1);
    chk("p0_irq_e3", {31'h0, irq}, 32'h1);
    cycles(2);
    rd(A_CTRL, v); chk("p0_ctrl_en_clr", v, 32'h8);
    chk("p0_irq_held", {31'h0, irq}, 32'h1);

    // Async reset while irq is high
    #1 reset = 1'b0;
    #1;
    chk("arst_irq_hi", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
